// File: rtl/pipe_share_pkg.sv
// Shared types and helpers for the pipe_share_arb slice.
//   DW_DEFAULT : default operand width of the shared datapath
//   tag_t      : {v, id} entry carried alongside an issued operand
//   pick_t     : {found, idx} result of a round-robin search
//   rr_pick()  : first asserted request after the last-grant pointer, modulo nreq
package pipe_share_pkg;

   localparam int unsigned DW_DEFAULT = 25;
   localparam int unsigned NREQ_MAX   = 8;
   localparam int unsigned IDW_MAX    = 3;

   // The ID field is sized for the largest supported requester count; narrower
   // configurations only use the low IDW bits.
   typedef struct packed {
      logic               v;
      logic [IDW_MAX-1:0] id;
   } tag_t;

   typedef struct packed {
      logic               found;
      logic [IDW_MAX-1:0] idx;
   } pick_t;

   // Search order lp+1, lp+2, ... wrapping modulo nreq, so lp itself is tried last.
   function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                     input logic [IDW_MAX-1:0]  lp,
                                     input int unsigned          nreq);
      pick_t              res;
      logic [IDW_MAX-1:0] cand;
      res = '0;
      for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
         cand = IDW_MAX'((32'(lp) + k) % nreq);
         if (k <= nreq && !res.found && req[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pipe_share_arb_if.sv
// Bus between the requesters / shared datapath and pipe_share_arb.
//   en, req, req_data        : requester side inputs to the arbiter
//   gnt                      : one-hot combinational accept
//   pipe_in_data             : operand into the shared datapath
//   pipe_out_data            : datapath result, LAT cycles after issue
//   rsp_valid/rsp_id/rsp_data: registered result returned to the owner
//   busy                     : items in flight or a response pending
// Modport slave is the arbiter; master is the surrounding environment.
interface pipe_share_arb_if
   import pipe_share_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = DW_DEFAULT,
   parameter int unsigned IDW  = 2
);

   logic                 en;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      gnt;
   logic [DW-1:0]        pipe_in_data;
   logic [DW-1:0]        pipe_out_data;
   logic [NREQ-1:0]      rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [DW-1:0]        rsp_data;
   logic                 busy;

   modport master (
      output en, req, req_data, pipe_out_data,
      input  gnt, pipe_in_data, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  en, req, req_data, pipe_out_data,
      output gnt, pipe_in_data, rsp_valid, rsp_id, rsp_data, busy
   );

endinterface

// File: rtl/pipe_tag_delay.sv
// LAT-deep shift register of {v, id} tags that mirrors the external datapath
// latency, so the tag leaving the last stage belongs to the current result.
//   clk    : clock
//   clr_i  : synchronous clear of every stage
//   tag_i  : tag captured into stage 0 each cycle
//   tag_o  : last stage
//   any_v_o: OR of all stage valid bits
module pipe_tag_delay
   import pipe_share_pkg::*;
#(
   parameter int unsigned LAT = 3
) (
   input  logic clk,
   input  logic clr_i,
   input  tag_t tag_i,
   output tag_t tag_o,
   output logic any_v_o
);

   tag_t tags_q [LAT];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            tags_q[i] <= '0;
         end
      end else begin
         tags_q[0] <= tag_i;
         for (int unsigned i = 1; i < LAT; i++) begin
            tags_q[i] <= tags_q[i-1];
         end
      end
   end

   always_comb begin
      any_v_o = 1'b0;
      for (int unsigned i = 0; i < LAT; i++) begin
         any_v_o = any_v_o | tags_q[i].v;
      end
   end

   assign tag_o = tags_q[LAT-1];

endmodule

// File: rtl/pipe_share_arb.sv
// Round-robin scheduler sharing one fixed-latency, non-stallable datapath among
// NREQ requesters. At most one request is granted per cycle; its operand goes to
// the datapath and its {valid, id} tag travels through pipe_tag_delay so the
// result can be returned, registered, to the originator.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pipe_share_arb_if slave modport (handshake, datapath, response)
//   stats_clr  : (ARB_STATS_EN) synchronous clear of the grant counters
//   grant_cnt  : (ARB_STATS_EN) per-requester 16-bit saturating grant counts
// Build option: define ARB_STATS_EN to add the grant counters and their ports.
module pipe_share_arb
   import pipe_share_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 3,
   parameter int unsigned DW   = DW_DEFAULT,
   parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef ARB_STATS_EN
   input  logic                 stats_clr,
   output logic [NREQ*16-1:0]   grant_cnt,
`endif
   pipe_share_arb_if.slave      bus
);

   logic [IDW-1:0]      lp_q;
   logic [NREQ_MAX-1:0] req_ext;
   pick_t               pick;
   logic                grant_vld;
   logic [IDW-1:0]      winner;
   logic [NREQ-1:0]     gnt_int;
   logic [DW-1:0]       pipe_in;
   tag_t                tag_in;
   tag_t                tag_tail;
   logic                tags_any_v;
   logic [IDW-1:0]      tail_id;
   logic [NREQ-1:0]     tail_onehot;
   logic [NREQ-1:0]     rsp_valid_q;
   logic [IDW-1:0]      rsp_id_q;
   logic [DW-1:0]       rsp_data_q;

   // ---------------- Arbitration ----------------
   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = bus.req;
   end

   assign pick      = rr_pick(req_ext, IDW_MAX'(lp_q), NREQ);
   assign grant_vld = pick.found & bus.en & ~reset;
   assign winner    = IDW'(pick.idx);

   // The mux idles at zero so the datapath sees its reset value when nothing issues.
   always_comb begin
      gnt_int = '0;
      pipe_in = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_vld && winner == IDW'(i)) begin
            gnt_int[i] = 1'b1;
            pipe_in    = bus.req_data[i*DW +: DW];
         end
      end
   end

   assign bus.gnt          = gnt_int;
   assign bus.pipe_in_data = pipe_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         lp_q <= IDW'(NREQ - 1);
      end else if (grant_vld) begin
         lp_q <= winner;
      end
   end

   // ---------------- Tag pipeline ----------------
   always_comb begin
      tag_in    = '0;
      tag_in.v  = grant_vld;
      tag_in.id = IDW_MAX'(winner);
   end

   pipe_tag_delay #(
      .LAT (LAT)
   ) u_tag_delay (
      .clk     (clk),
      .clr_i   (reset),
      .tag_i   (tag_in),
      .tag_o   (tag_tail),
      .any_v_o (tags_any_v)
   );

   // ---------------- Response register ----------------
   assign tail_id = IDW'(tag_tail.id);

   always_comb begin
      tail_onehot = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         tail_onehot[i] = tag_tail.v && (tail_id == IDW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= tail_onehot;
         rsp_id_q    <= tail_id;
         if (tag_tail.v) begin
            rsp_data_q <= bus.pipe_out_data;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = tags_any_v | (|rsp_valid_q);

   // ---------------- Optional grant statistics ----------------
`ifdef ARB_STATS_EN
   logic [NREQ-1:0][15:0] cnt_q;

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || stats_clr) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_int[i] && cnt_q[i] != 16'hFFFF) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/pipe_share_arb.md
Name: pipe_share_arb

Overview:
Round-robin scheduler that shares one fixed-latency, non-stallable 25-bit signed datapath (a reset-to-zero register chain of depth LAT) between NREQ requesters.
- Selects at most one request per cycle and drives the selected operand into the datapath.
- Carries the requester ID and valid flag alongside the data for LAT cycles.
- Routes each result back to its originator.
- Sits between the filter-tap producers and the shared pipelined arithmetic stage.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 3, shared datapath latency in clock edges (1..8)
DW, 25, data width, two's-complement signed
IDW, 2, ID width, equal to clog2(NREQ) (minimum 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  grant enable; low blocks new grants while in-flight items drain
req  in  NREQ  per-requester request, held until granted
req_data  in  NREQ*DW  operands packed, requester i at bits [i*DW +: DW]
gnt  out  NREQ  one-hot accept (combinational); request is consumed in a cycle where req[i]&gnt[i]
pipe_in_data  out  DW  operand to the shared datapath (combinational mux)
pipe_out_data  in  DW  datapath result, valid LAT cycles after issue
rsp_valid  out  NREQ  one-hot registered result strobe
rsp_id  out  IDW  registered ID of the result owner
rsp_data  out  DW  registered result
busy  out  1  high while any item is in flight or a response is pending

Behaviour:
Arbitration:
- Round-robin with a last-grant pointer lp (IDW bits).
- Search order is lp+1, lp+2, ... modulo NREQ; the first asserted req wins.
- gnt is all-zero when en=0, when req=0, or while reset=1.
- lp updates to the winner on the clock edge of any cycle with a grant; it is unchanged otherwise.
- Reset value of lp is NREQ-1, so requester 0 has priority first.
- A single continuous requester is granted every cycle, giving throughput 1/cycle.

Data path:
- pipe_in_data = req_data of the winner.
- pipe_in_data is 0 when there is no grant, matching the datapath's idle/reset value.

Tag pipeline:
- Shift register of LAT entries, each {v, id}, advanced every cycle.
- Stage 0 captures {|gnt, winner}.

Response:
- Each cycle, rsp_valid <= onehot(tag[LAT-1].id) when tag[LAT-1].v is set, else 0.
- rsp_id <= tag[LAT-1].id.
- rsp_data <= pipe_out_data when tag[LAT-1].v is set; rsp_data holds its value otherwise.
- Grant in cycle t gives rsp_valid in cycle t+LAT+1.
- No backpressure: the receiver must accept every strobe.

busy = OR of all tag v bits OR |rsp_valid.

en deassertion mid-operation:
- In-flight items complete normally.
- lp is held.

Reset:
- Clears all tag entries, lp = NREQ-1, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
- Items in flight at reset are dropped with no response.
- The first grant is possible in the first cycle after reset deasserts.

req bits at indices >= NREQ do not exist; ID wrap-around is modulo NREQ (NREQ need not be a power of 2).

Optional Feature:
ARB_STATS_EN
- Defined: adds output grant_cnt (NREQ*16 bits) with one 16-bit saturating counter per requester.
  - Each counter increments on every grant to that requester and saturates at 0xFFFF.
  - All counters clear on reset.
  - Adds input stats_clr (1 bit), a synchronous clear that takes precedence over increment.
- Not defined: no counters, and no grant_cnt or stats_clr ports.

Decomposition:
Shared package pipe_share_pkg:
- DW_DEFAULT = 25.
- Typedef tag_t {logic v; logic [IDW-1:0] id}.
- Function rr_pick(req, lp) returning {found, idx}.

Sub-module:
- One natural sub-module, pipe_tag_delay: a LAT-deep tag shift register with synchronous clear.
- It mirrors the external datapath latency.
- Arbiter and response register stay in the top level.

Test Plan:
- Reset, then req=4'b1111 continuous with en=1 -> gnt sequence 0,1,2,3,0,1; first rsp_valid=4'b0001 at 4 cycles after the first grant (LAT=3); rsp_data equals the modelled datapath output.
- req=4'b0100 only, held 10 cycles -> gnt=4'b0100 every cycle; 10 consecutive rsp_valid=4'b0100 strobes with rsp_id=2; busy high until 1 cycle after the last strobe.
- Grant requester 1, then req=4'b1011 -> next gnt goes to 3 (not 0), then 0, then 1.
- Issue 3 grants, then drop en -> gnt=0 immediately; 3 responses still delivered; busy falls to 0 after the last one.
- Assert reset with 2 items in flight -> no rsp_valid strobe afterwards; lp reset means req=4'b1111 is granted to 0 first.
- With ARB_STATS_EN defined: 70000 grants to requester 0 -> grant_cnt[0] = 0xFFFF; stats_clr asserted in the same cycle as a grant -> counter reads 0 next cycle.
